// File: rtl/eth_rxframectrl.sv
// Receive frame control: strips preamble/SFD, forwards frame bytes one cycle after MRxD, checks address/length, enforces IFG.
// Status is held on a valid/ready pair; frames that arrive while status is pending are discarded and flagged via StatMissed.
module eth_rxframectrl #(
    parameter int IFG_CYCLES = 12,
    parameter int MINFL      = 64
) (
    input  logic        MRxClk,
    input  logic        Reset,
    input  logic        MRxDV,
    input  logic [7:0]  MRxD,
    input  logic [47:0] MAC,
    input  logic [15:0] MaxFL,
    input  logic        HugEn,
    input  logic        r_IFG,
    output logic [7:0]  RxData,
    output logic        RxDataValid,
    output logic        RxStartFrm,
    output logic        RxEndFrm,
    output logic [15:0] ByteCnt,
    output logic        StatValid,
    input  logic        StatReady,
    output logic [15:0] StatLen,
    output logic        StatTooLong,
    output logic        StatTooShort,
    output logic        StatAddrMiss,
    output logic        StatMissed
);

    localparam int IW = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);
    localparam logic [IW-1:0] IFG_MAX = IW'(IFG_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP, S_STATUS} state_t;

    state_t        state_q, state_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_start_q, rx_start_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic          stat_vld_q, stat_vld_d;
    logic [15:0]   stat_len_q, stat_len_d;
    logic          too_long_q, too_long_d;
    logic          too_short_q, too_short_d;
    logic          addr_miss_q, addr_miss_d;
    logic          missed_q, missed_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic          dv_q, dv_d;
    logic          mac_hit_q, mac_hit_d;
    logic          bc_hit_q, bc_hit_d;
    logic          trunc_q, trunc_d;

    logic [7:0] mac_byte;
    logic       max_hit;

    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt_q[2:0])
            3'd0:    mac_byte = MAC[47:40];
            3'd1:    mac_byte = MAC[39:32];
            3'd2:    mac_byte = MAC[31:24];
            3'd3:    mac_byte = MAC[23:16];
            3'd4:    mac_byte = MAC[15:8];
            3'd5:    mac_byte = MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // Byte currently on RxData hits MaxFL while more data is still arriving.
    assign max_hit = rx_vld_q && !HugEn && (byte_cnt_q == MaxFL);

    always_comb begin
        state_d     = state_q;
        rx_data_d   = rx_data_q;
        rx_vld_d    = 1'b0;
        rx_start_d  = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        stat_vld_d  = stat_vld_q;
        stat_len_d  = stat_len_q;
        too_long_d  = too_long_q;
        too_short_d = too_short_q;
        addr_miss_d = addr_miss_q;
        missed_d    = 1'b0;
        ifg_d       = ifg_q;
        dv_d        = MRxDV;
        mac_hit_d   = mac_hit_q;
        bc_hit_d    = bc_hit_q;
        trunc_d     = trunc_q;

        if (!MRxDV) begin
            if (dv_q)
                ifg_d = '0;
            else if (ifg_q < IFG_MAX)
                ifg_d = ifg_q + IW'(1);
        end

        case (state_q)
            S_IDLE, S_PREAMBLE: begin
                if (!MRxDV) begin
                    state_d = S_IDLE;
                end else if (state_q == S_IDLE && !r_IFG && ifg_q < IFG_MAX) begin
                    state_d = S_DROP;
                end else if (MRxD == 8'h55) begin
                    state_d = S_PREAMBLE;
                end else if (MRxD == 8'hD5) begin
                    state_d    = S_DATA;
                    byte_cnt_d = '0;
                    mac_hit_d  = 1'b1;
                    bc_hit_d   = 1'b1;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (!MRxDV || max_hit) begin
                    stat_len_d  = byte_cnt_q;
                    too_long_d  = MRxDV;
                    too_short_d = byte_cnt_q < 16'(MINFL);
                    addr_miss_d = !(byte_cnt_q >= 16'd6 && (mac_hit_q || bc_hit_q));
                    if (!MRxDV) begin
                        stat_vld_d = 1'b1;
                        state_d    = S_STATUS;
                    end else begin
                        trunc_d = 1'b1;
                        state_d = S_DROP;
                    end
                end else begin
                    rx_data_d  = MRxD;
                    rx_vld_d   = 1'b1;
                    rx_start_d = (byte_cnt_q == 16'd0);
                    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    if (byte_cnt_q < 16'd6) begin
                        mac_hit_d = mac_hit_q && (MRxD == mac_byte);
                        bc_hit_d  = bc_hit_q && (MRxD == 8'hFF);
                    end
                end
            end
            S_DROP: begin
                if (!MRxDV) begin
                    trunc_d = 1'b0;
                    if (trunc_q) begin
                        stat_vld_d = 1'b1;
                        state_d    = S_STATUS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_STATUS: begin
                if (StatReady) begin
                    stat_vld_d = 1'b0;
                    // A frame already running during status is discarded to its end; a fresh rise is re-evaluated.
                    state_d    = (MRxDV && dv_q) ? S_DROP : S_IDLE;
                end else if (MRxDV && !dv_q) begin
                    missed_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MRxClk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            rx_start_q  <= 1'b0;
            byte_cnt_q  <= '0;
            stat_vld_q  <= 1'b0;
            stat_len_q  <= '0;
            too_long_q  <= 1'b0;
            too_short_q <= 1'b0;
            addr_miss_q <= 1'b0;
            missed_q    <= 1'b0;
            ifg_q       <= IFG_MAX;
            dv_q        <= 1'b0;
            mac_hit_q   <= 1'b0;
            bc_hit_q    <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            rx_start_q  <= rx_start_d;
            byte_cnt_q  <= byte_cnt_d;
            stat_vld_q  <= stat_vld_d;
            stat_len_q  <= stat_len_d;
            too_long_q  <= too_long_d;
            too_short_q <= too_short_d;
            addr_miss_q <= addr_miss_d;
            missed_q    <= missed_d;
            ifg_q       <= ifg_d;
            dv_q        <= dv_d;
            mac_hit_q   <= mac_hit_d;
            bc_hit_q    <= bc_hit_d;
            trunc_q     <= trunc_d;
        end
    end

    assign RxData       = rx_data_q;
    assign RxDataValid  = rx_vld_q;
    assign RxStartFrm   = rx_start_q;
    assign RxEndFrm     = rx_vld_q && (!MRxDV || max_hit);
    assign ByteCnt      = byte_cnt_q;
    assign StatValid    = stat_vld_q;
    assign StatLen      = stat_len_q;
    assign StatTooLong  = too_long_q;
    assign StatTooShort = too_short_q;
    assign StatAddrMiss = addr_miss_q;
    assign StatMissed   = missed_q;

endmodule

// File: tb/tb_eth_rxframectrl.sv
// Directed bench for eth_rxframectrl: frames driven after each rising edge, outputs observed on the falling edge.
module tb_eth_rxframectrl;

    logic        MRxClk = 1'b0;
    logic        Reset, MRxDV, HugEn, r_IFG, StatReady;
    logic [7:0]  MRxD;
    logic [47:0] MAC;
    logic [15:0] MaxFL;
    logic [7:0]  RxData;
    logic        RxDataValid, RxStartFrm, RxEndFrm, StatValid;
    logic [15:0] ByteCnt, StatLen;
    logic        StatTooLong, StatTooShort, StatAddrMiss, StatMissed;

    always #5 MRxClk = ~MRxClk;

    eth_rxframectrl #(.IFG_CYCLES(12), .MINFL(64)) dut (
        .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD), .MAC(MAC),
        .MaxFL(MaxFL), .HugEn(HugEn), .r_IFG(r_IFG),
        .RxData(RxData), .RxDataValid(RxDataValid), .RxStartFrm(RxStartFrm),
        .RxEndFrm(RxEndFrm), .ByteCnt(ByteCnt), .StatValid(StatValid),
        .StatReady(StatReady), .StatLen(StatLen), .StatTooLong(StatTooLong),
        .StatTooShort(StatTooShort), .StatAddrMiss(StatAddrMiss), .StatMissed(StatMissed)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    logic [7:0]  fbytes [0:255];
    int          n_out, n_start, start_at, n_end, end_cnt, n_stat, n_missed, mon_idx;
    logic [15:0] c_len;
    logic        c_long, c_short, c_miss;

    always @(negedge MRxClk) begin
        if (RxDataValid) begin
            n_out++;
            if (RxStartFrm) begin
                n_start++;
                start_at = n_out;
                mon_idx  = 0;
            end else begin
                mon_idx++;
            end
            if (mon_idx < 256)
                chk("rxdata", {24'h0, RxData}, {24'h0, fbytes[mon_idx]});
            if (RxEndFrm) begin
                n_end++;
                end_cnt = int'(ByteCnt);
            end
        end
        if (StatValid && StatReady) begin
            n_stat++;
            c_len   = StatLen;
            c_long  = StatTooLong;
            c_short = StatTooShort;
            c_miss  = StatAddrMiss;
        end
        if (StatMissed)
            n_missed++;
    end

    task automatic clr_mon();
        n_out = 0; n_start = 0; start_at = 0; n_end = 0; end_cnt = 0;
        n_stat = 0; n_missed = 0; mon_idx = 0;
        c_len = '0; c_long = 1'b0; c_short = 1'b0; c_miss = 1'b0;
    endtask

    task automatic cyc();
        @(posedge MRxClk);
        #1;
    endtask

    task automatic gap(input int n);
        MRxDV = 1'b0;
        MRxD  = 8'h00;
        repeat (n) cyc();
    endtask

    task automatic send_frame(input int len, input logic [47:0] dst, input int rst_at);
        logic [47:0] sh;
        for (int i = 0; i < len && i < 256; i++) begin
            sh = dst >> (8 * (5 - i));
            fbytes[i] = (i < 6) ? sh[7:0] : 8'((i * 7 + 3) % 256);
        end
        MRxDV = 1'b1;
        for (int i = 0; i < 7; i++) begin
            MRxD = 8'h55;
            cyc();
        end
        MRxD = 8'hD5;
        cyc();
        for (int i = 0; i < len; i++) begin
            Reset = (i == rst_at);
            MRxD  = (i < 256) ? fbytes[i] : 8'((i * 7 + 3) % 256);
            cyc();
            if (i == rst_at) begin
                Reset = 1'b0;
                @(negedge MRxClk);
                chk("rst_vld", {31'h0, RxDataValid}, 32'h0);
                chk("rst_cnt", {16'h0, ByteCnt}, 32'h0);
                chk("rst_end", {31'h0, RxEndFrm}, 32'h0);
                chk("rst_svld", {31'h0, StatValid}, 32'h0);
                chk("rst_data", {24'h0, RxData}, 32'h0);
            end
        end
        Reset = 1'b0;
        MRxDV = 1'b0;
        MRxD  = 8'h00;
        cyc();
    endtask

    task automatic chk_stat(input string tag, input int len, input logic lng, input logic sht, input logic miss);
        chk({tag, "_nstat"}, n_stat, 1);
        chk({tag, "_len"}, {16'h0, c_len}, len);
        chk({tag, "_long"}, {31'h0, c_long}, {31'h0, lng});
        chk({tag, "_short"}, {31'h0, c_short}, {31'h0, sht});
        chk({tag, "_miss"}, {31'h0, c_miss}, {31'h0, miss});
    endtask

    initial begin
        Reset = 1'b1; MRxDV = 1'b0; MRxD = 8'h00;
        MAC = 48'h0012_3456_789A; MaxFL = 16'd1518; HugEn = 1'b0; r_IFG = 1'b0; StatReady = 1'b1;
        clr_mon();
        repeat (3) cyc();
        Reset = 1'b0;
        @(negedge MRxClk);
        chk("reset_vld", {31'h0, RxDataValid}, 32'h0);
        chk("reset_cnt", {16'h0, ByteCnt}, 32'h0);
        chk("reset_svld", {31'h0, StatValid}, 32'h0);
        chk("reset_missed", {31'h0, StatMissed}, 32'h0);
        chk("reset_len", {16'h0, StatLen}, 32'h0);

        // 64-byte unicast frame to our station
        clr_mon();
        send_frame(64, MAC, -1);
        gap(20);
        chk("uc_nout", n_out, 64);
        chk("uc_nstart", n_start, 1);
        chk("uc_start_at", start_at, 1);
        chk("uc_nend", n_end, 1);
        chk("uc_endcnt", end_cnt, 64);
        chk_stat("uc", 64, 1'b0, 1'b0, 1'b0);

        // 40-byte broadcast: short but address accepted
        clr_mon();
        send_frame(40, 48'hFFFF_FFFF_FFFF, -1);
        gap(20);
        chk("bc_nout", n_out, 40);
        chk_stat("bc", 40, 1'b0, 1'b1, 1'b0);

        // foreign destination
        clr_mon();
        send_frame(70, MAC ^ 48'h0000_0000_0100, -1);
        gap(20);
        chk_stat("miss", 70, 1'b0, 1'b0, 1'b1);

        // runt below 6 bytes always misses
        clr_mon();
        send_frame(4, MAC, -1);
        gap(20);
        chk_stat("runt", 4, 1'b0, 1'b1, 1'b1);

        // MaxFL truncation, then same frame with HugEn
        MaxFL = 16'd100;
        clr_mon();
        send_frame(150, MAC, -1);
        gap(20);
        chk("long_nout", n_out, 100);
        chk("long_nend", n_end, 1);
        chk("long_endcnt", end_cnt, 100);
        chk_stat("long", 100, 1'b1, 1'b0, 1'b0);
        HugEn = 1'b1;
        clr_mon();
        send_frame(150, MAC, -1);
        gap(20);
        chk("hug_nout", n_out, 150);
        chk_stat("hug", 150, 1'b0, 1'b0, 1'b0);
        HugEn = 1'b0;
        MaxFL = 16'd1518;

        // second frame 5 idle cycles after the fall: dropped with IFG check, accepted without
        clr_mon();
        send_frame(64, MAC, -1);
        gap(4);
        send_frame(64, MAC, -1);
        gap(20);
        chk("ifg_nout", n_out, 64);
        chk("ifg_nstat", n_stat, 1);
        r_IFG = 1'b1;
        clr_mon();
        send_frame(64, MAC, -1);
        gap(4);
        send_frame(64, MAC, -1);
        gap(20);
        chk("noifg_nout", n_out, 128);
        chk("noifg_nstat", n_stat, 2);
        chk("noifg_nend", n_end, 2);
        r_IFG = 1'b0;

        // status held while a second frame arrives
        StatReady = 1'b0;
        clr_mon();
        send_frame(70, MAC ^ 48'h0000_0000_0001, -1);
        gap(20);
        send_frame(64, MAC, -1);
        gap(20);
        chk("hold_nout", n_out, 70);
        chk("hold_missed", n_missed, 1);
        chk("hold_svld", {31'h0, StatValid}, 32'h1);
        chk("hold_len", {16'h0, StatLen}, 32'd70);
        chk("hold_miss", {31'h0, StatAddrMiss}, 32'h1);
        StatReady = 1'b1;
        cyc();
        cyc();
        chk_stat("hold", 70, 1'b0, 1'b0, 1'b1);
        chk("hold_svld_after", {31'h0, StatValid}, 32'h0);
        gap(20);

        // reset at byte 20, then a clean frame
        clr_mon();
        send_frame(64, MAC, 20);
        gap(20);
        chk("rst_nout", n_out, 20);
        chk("rst_nend", n_end, 0);
        chk("rst_nstat", n_stat, 0);
        clr_mon();
        send_frame(64, MAC, -1);
        gap(20);
        chk("post_nout", n_out, 64);
        chk_stat("post", 64, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
